prog_automata_monitor: RTL and testbench
========================================

// Module: prog_automata_monitor
// PURPOSE
//  Runtime-programmable homogeneous automata engine for the RM monitor clusters; generalises the fixed
//  per-property STE netlists into one block with N_STE states, SYM_W-bit symbols and a CSR-loaded
//  symbol-class/edge/start/report table. Consumes a symbol stream via valid/ready, advances all STEs in
//  lock-step and queues non-zero report vectors in a FIFO for the monitor aggregator.
// PARAMETERS
//  N_STE      16  number of STEs, 2..32 (one edge row = one 32-bit word)
//  SYM_W      8   symbol width, 5..8; class table = 2**SYM_W bits per STE
//  FIFO_DEPTH 8   report FIFO entries, power of 2, >=2
// PORTS
//  clk_i        in   1            clock
//  rst_ni       in   1            async active-low reset
//  run_i        in   1            engine enabled; config writes allowed only when 0
//  clear_i      in   1            sync soft clear (pulse)
//  sym_valid_i  in   1            symbol valid
//  sym_i        in   SYM_W        symbol
//  sym_ready_o  out  1            symbol accepted when valid&ready
//  cfg_we_i     in   1            config write strobe
//  cfg_sel_i    in   2            0=class word, 1=edge row, 2=flags, 3=reserved
//  cfg_ste_i    in   clog2(N_STE) target STE
//  cfg_word_i   in   SYM_W-5      class word index (bits [32w+31:32w]); ignored for sel 1/2
//  cfg_wdata_i  in   32           write data
//  cfg_err_o    out  1            1-cycle pulse: write rejected
//  active_o     out  N_STE        registered STE active vector
//  report_o     out  N_STE        active_o & report_mask
//  rpt_valid_o  out  1            FIFO non-empty
//  rpt_data_o   out  RPT_W        head entry; RPT_W = N_STE (+32 with TS macro)
//  rpt_ready_i  in   1            pop when valid&ready
//  rpt_cnt_o    out  clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  - Reset: all outputs 0, active/FIFO/sym index cleared, sod_armed=1, config tables cleared to 0.
//  - Per STE i: flags bit0 start_sod, bit1 start_all, bit2 report; edge row i bit j = edge j->i.
//  - Accept (sym_valid_i & sym_ready_o), cycle t: en[i] = |(active & edge_col[i]) | start_all[i]
//    | (start_sod[i] & sod_armed); active[i] <= en[i] & class[i][sym_i]; visible at t+1. sod_armed <= 0.
//  - No accept: active holds (no decay), sod_armed holds.
//  - Push: cycle after an accept, if report_o != 0 push {ts?, report_o}; one push max per cycle.
//  - sym_ready_o = run_i & !clear_i & (rpt_cnt_o + push_now < FIFO_DEPTH); FIFO can never overflow,
//    no data dropped; push and pop in the same cycle allowed at any occupancy incl. full.
//  - Pop from empty FIFO ignored; rpt_data_o = 0 when empty.
//  - clear_i (highest priority): active, FIFO, sym index -> 0, sod_armed -> 1; pending push cancelled;
//    config tables kept.
//  - run_i low: sym_ready_o=0, state held, FIFO still drains.
//  - Config write with run_i=1, cfg_sel_i=3 or cfg_ste_i>=N_STE: no table change, cfg_err_o=1 next cycle.
//    Edge/flag writes use only low N_STE/3 bits.
//  - Symbol index: 32-bit, increments per accept, wraps 0xFFFFFFFF->0; first symbol after reset/clear = 0.
// CONFIGURATION
//  AUTOMATA_REPORT_TS_EN defined: each FIFO entry = {sym_index[31:0] of reporting symbol, report};
//    RPT_W = N_STE+32.
//  Undefined: entry = report only, RPT_W = N_STE, no index counter synthesised.
// TESTING
//  1 Reset mid-stream (rst_ni low 1 cycle, async) -> all outputs 0 same cycle, sod re-armed, cfg zeroed.
//  2 STE0 start_sod, class 0x00-0x0F, report; STE1 edge 0->1, class 0x10, report; symbols 0x05,0x10
//    -> report_o 0x1 then 0x2; FIFO holds 2 entries (ts 0,1 with macro); 0x05 again -> no report.
//  3 STE0 start_all, class all-ones, report; rpt_ready_i=0, FIFO_DEPTH=8 -> exactly 8 symbols accepted,
//    sym_ready_o=0 afterwards; pop one -> exactly one more accepted; no entry lost.
//  4 Self-loop STE (edge 2->2, class 0x00-0x3F): 0x10,0x20,0x50 -> active 1,1,0; clear_i then 0x10
//    -> start-of-data re-arms, sym index restarts at 0.
//  5 Config write with run_i=1 -> cfg_err_o pulse, table unchanged; cfg_ste_i=N_STE -> cfg_err_o.
//  6 TS macro: preload index 0xFFFFFFFE via 2**32-2 accepts (force) -> entries tagged FFFFFFFE,FFFFFFFF,0.

Source files
------------

// File: rtl/prog_automata_monitor.sv
// Programmable homogeneous automata engine: CSR-loaded STE tables, lock-step update, report FIFO.
// Define AUTOMATA_REPORT_TS_EN to tag each FIFO entry with the 32-bit index of its symbol.
module prog_automata_monitor #(
    parameter int N_STE      = 16,
    parameter int SYM_W      = 8,
    parameter int FIFO_DEPTH = 8,
    localparam int STE_W     = $clog2(N_STE),
    localparam int CW_W      = (SYM_W > 5) ? SYM_W - 5 : 1,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
`ifdef AUTOMATA_REPORT_TS_EN
    localparam int RPT_W     = N_STE + 32
`else
    localparam int RPT_W     = N_STE
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic              clear_i,
    input  logic              sym_valid_i,
    input  logic [SYM_W-1:0]  sym_i,
    output logic              sym_ready_o,
    input  logic              cfg_we_i,
    input  logic [1:0]        cfg_sel_i,
    input  logic [STE_W-1:0]  cfg_ste_i,
    input  logic [CW_W-1:0]   cfg_word_i,
    input  logic [31:0]       cfg_wdata_i,
    output logic              cfg_err_o,
    output logic [N_STE-1:0]  active_o,
    output logic [N_STE-1:0]  report_o,
    output logic              rpt_valid_o,
    output logic [RPT_W-1:0]  rpt_data_o,
    input  logic              rpt_ready_i,
    output logic [PTR_W:0]    rpt_cnt_o
);

    localparam int NCLS   = 2 ** SYM_W;
    localparam int NWORDS = NCLS / 32;

    logic [N_STE-1:0][NCLS-1:0]  cls_q, cls_d;
    logic [N_STE-1:0][N_STE-1:0] edge_tab_q, edge_tab_d;
    logic [N_STE-1:0][2:0]       flags_q, flags_d;
    logic [N_STE-1:0]            active_q, active_d;
    logic                        sod_armed_q, sod_armed_d;
    logic                        pend_q, pend_d;
    logic                        cfg_err_q, cfg_err_d;
    logic [FIFO_DEPTH-1:0][RPT_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]              cnt_q, cnt_d;
    logic [N_STE-1:0]            rpt_mask, start_all, start_sod, en;
    logic [RPT_W-1:0]            entry;
    logic                        accept, push_now, pop, cfg_ok;
    int                          widx;

`ifdef AUTOMATA_REPORT_TS_EN
    logic [31:0] sym_idx_q, sym_idx_d, ts_pend_q, ts_pend_d;
    assign entry = {ts_pend_q, report_o};
`else
    assign entry = report_o;
`endif

    always_comb begin
        start_sod = '0;
        start_all = '0;
        rpt_mask  = '0;
        en        = '0;
        for (int i = 0; i < N_STE; i++) begin
            start_sod[i] = flags_q[i][0];
            start_all[i] = flags_q[i][1];
            rpt_mask[i]  = flags_q[i][2];
            en[i] = (|(active_q & edge_tab_q[i])) | flags_q[i][1]
                  | (flags_q[i][0] & sod_armed_q);
        end
    end

    assign report_o    = active_q & rpt_mask;
    assign active_o    = active_q;
    assign cfg_err_o   = cfg_err_q;
    assign rpt_cnt_o   = cnt_q;
    assign rpt_valid_o = (cnt_q != '0);
    assign rpt_data_o  = rpt_valid_o ? mem_q[rptr_q] : '0;

    // A push in flight counts against free space, so an accepted symbol always has a slot.
    assign push_now    = pend_q & (|report_o) & !clear_i;
    assign sym_ready_o = rst_ni & run_i & !clear_i
                       & (({1'b0, cnt_q} + (PTR_W+2)'(push_now))
                          < (PTR_W+2)'(FIFO_DEPTH));
    assign accept      = sym_valid_i & sym_ready_o;
    assign pop         = rpt_ready_i & rpt_valid_o;

    always_comb begin
        active_d    = active_q;
        sod_armed_d = sod_armed_q;
        pend_d      = accept;
        mem_d       = mem_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        cnt_d       = cnt_q + (PTR_W+1)'(push_now) - (PTR_W+1)'(pop);
`ifdef AUTOMATA_REPORT_TS_EN
        sym_idx_d   = sym_idx_q + 32'(accept);
        ts_pend_d   = accept ? sym_idx_q : ts_pend_q;
`endif
        if (accept) begin
            for (int i = 0; i < N_STE; i++)
                active_d[i] = en[i] & cls_q[i][sym_i];
            sod_armed_d = 1'b0;
        end
        if (push_now) begin
            mem_d[wptr_q] = entry;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (pop)
            rptr_d = rptr_q + PTR_W'(1);
        if (clear_i) begin
            active_d    = '0;
            sod_armed_d = 1'b1;
            pend_d      = 1'b0;
            wptr_d      = '0;
            rptr_d      = '0;
            cnt_d       = '0;
`ifdef AUTOMATA_REPORT_TS_EN
            sym_idx_d   = '0;
            ts_pend_d   = '0;
`endif
        end
    end

    always_comb begin
        cls_d      = cls_q;
        edge_tab_d = edge_tab_q;
        flags_d    = flags_q;
        widx       = int'(cfg_word_i) % NWORDS;
        cfg_ok     = cfg_we_i & !run_i & (cfg_sel_i != 2'd3)
                   & (int'(cfg_ste_i) < N_STE);
        cfg_err_d  = cfg_we_i & !cfg_ok;
        if (cfg_ok) begin
            case (cfg_sel_i)
                2'd0:    cls_d[cfg_ste_i][32*widx +: 32] = cfg_wdata_i;
                2'd1:    edge_tab_d[cfg_ste_i] = cfg_wdata_i[N_STE-1:0];
                2'd2:    flags_d[cfg_ste_i] = cfg_wdata_i[2:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cls_q       <= '0;
            edge_tab_q  <= '0;
            flags_q     <= '0;
            active_q    <= '0;
            sod_armed_q <= 1'b1;
            pend_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            mem_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
`ifdef AUTOMATA_REPORT_TS_EN
            sym_idx_q   <= '0;
            ts_pend_q   <= '0;
`endif
        end else begin
            cls_q       <= cls_d;
            edge_tab_q  <= edge_tab_d;
            flags_q     <= flags_d;
            active_q    <= active_d;
            sod_armed_q <= sod_armed_d;
            pend_q      <= pend_d;
            cfg_err_q   <= cfg_err_d;
            mem_q       <= mem_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
`ifdef AUTOMATA_REPORT_TS_EN
            sym_idx_q   <= sym_idx_d;
            ts_pend_q   <= ts_pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_prog_automata_monitor.sv
// Directed bench for prog_automata_monitor (12 STEs, 8-bit symbols, 8-entry FIFO)
// with a queue scoreboard of expected report entries.
module tb_prog_automata_monitor;

    localparam int N  = 12;
    localparam int SW = 8;
    localparam int FD = 8;
`ifdef AUTOMATA_REPORT_TS_EN
    localparam int RW = N + 32;
`else
    localparam int RW = N;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          run_i, clear_i, sym_valid_i, sym_ready_o;
    logic [SW-1:0] sym_i;
    logic          cfg_we_i, cfg_err_o;
    logic [1:0]    cfg_sel_i;
    logic [3:0]    cfg_ste_i;
    logic [2:0]    cfg_word_i;
    logic [31:0]   cfg_wdata_i;
    logic [N-1:0]  active_o, report_o;
    logic          rpt_valid_o, rpt_ready_i;
    logic [RW-1:0] rpt_data_o;
    logic [3:0]    rpt_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0]   exp_idx;
    logic [RW-1:0] exp_q[$];

    prog_automata_monitor #(.N_STE(N), .SYM_W(SW), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .clear_i(clear_i),
        .sym_valid_i(sym_valid_i), .sym_i(sym_i), .sym_ready_o(sym_ready_o),
        .cfg_we_i(cfg_we_i), .cfg_sel_i(cfg_sel_i), .cfg_ste_i(cfg_ste_i),
        .cfg_word_i(cfg_word_i), .cfg_wdata_i(cfg_wdata_i), .cfg_err_o(cfg_err_o),
        .active_o(active_o), .report_o(report_o), .rpt_valid_o(rpt_valid_o),
        .rpt_data_o(rpt_data_o), .rpt_ready_i(rpt_ready_i), .rpt_cnt_o(rpt_cnt_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk(input logic [31:0] ts, input logic [N-1:0] r);
`ifdef AUTOMATA_REPORT_TS_EN
        return {ts, r};
`else
        return RW'(r) | RW'(ts & 32'h0);
`endif
    endfunction

    task automatic cfg(input logic [1:0] sel, input logic [3:0] ste,
                       input logic [2:0] w, input logic [31:0] d);
        cfg_we_i = 1'b1; cfg_sel_i = sel; cfg_ste_i = ste;
        cfg_word_i = w; cfg_wdata_i = d;
        @(negedge clk_i);
        cfg_we_i = 1'b0;
    endtask

    task automatic send(input logic [SW-1:0] s);
        int b;
        b = 0;
        sym_i = s; sym_valid_i = 1'b1;
        #1;
        while (!sym_ready_o && b < 50) begin
            @(negedge clk_i); #1; b++;
        end
        chk("send_ready", 64'(sym_ready_o), 64'(1));
        @(negedge clk_i);
        sym_valid_i = 1'b0;
        exp_idx++;
    endtask

    task automatic pop_chk(input string tag);
        logic [RW-1:0] e;
        #1;
        chk({tag, "_valid"}, 64'(rpt_valid_o), 64'(1));
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(1));
        end else begin
            e = exp_q.pop_front();
            chk(tag, 64'(rpt_data_o), 64'(e));
        end
        rpt_ready_i = 1'b1;
        @(negedge clk_i);
        rpt_ready_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        exp_idx = 0;
    endtask

    initial begin
        int acc;
        rst_ni = 1'b0; run_i = 1'b0; clear_i = 1'b0; sym_valid_i = 1'b0;
        sym_i = '0; cfg_we_i = 1'b0; cfg_sel_i = '0; cfg_ste_i = '0;
        cfg_word_i = '0; cfg_wdata_i = '0; rpt_ready_i = 1'b0; exp_idx = 0;
        #1;
        chk("rst_active", 64'(active_o), 64'(0));
        chk("rst_cnt", 64'(rpt_cnt_o), 64'(0));
        chk("rst_valid", 64'(rpt_valid_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // basic two-STE chain
        cfg(2'd0, 4'd0, 3'd0, 32'h0000_FFFF);
        cfg(2'd2, 4'd0, 3'd0, 32'h5);
        cfg(2'd1, 4'd1, 3'd0, 32'h1);
        cfg(2'd0, 4'd1, 3'd0, 32'h0001_0000);
        cfg(2'd2, 4'd1, 3'd0, 32'h4);
        run_i = 1'b1;
        exp_q.push_back(mk(exp_idx, 12'h001));
        send(8'h05);
        chk("t2_act0", 64'(active_o), 64'h001);
        chk("t2_rep0", 64'(report_o), 64'h001);
        exp_q.push_back(mk(exp_idx, 12'h002));
        send(8'h10);
        chk("t2_act1", 64'(active_o), 64'h002);
        chk("t2_rep1", 64'(report_o), 64'h002);
        send(8'h05);
        chk("t2_act2", 64'(active_o), 64'h000);
        @(negedge clk_i); #1;
        chk("t2_cnt", 64'(rpt_cnt_o), 64'(2));
        pop_chk("t2_pop0");
        pop_chk("t2_pop1");

        // backpressure: FIFO fills with no pops
        run_i = 1'b0;
        do_clear();
        cfg(2'd2, 4'd0, 3'd0, 32'h6);
        for (int w = 0; w < 8; w++) cfg(2'd0, 4'd0, 3'(w), 32'hFFFF_FFFF);
        run_i = 1'b1; sym_i = 8'h20; sym_valid_i = 1'b1;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (sym_ready_o) begin
                acc++;
                exp_q.push_back(mk(exp_idx, 12'h001));
                exp_idx++;
            end
            @(negedge clk_i);
        end
        sym_valid_i = 1'b0;
        #1;
        chk("t3_accepts", 64'(acc), 64'(8));
        chk("t3_cnt_full", 64'(rpt_cnt_o), 64'(8));
        chk("t3_ready_full", 64'(sym_ready_o), 64'(0));
        sym_valid_i = 1'b1;
        pop_chk("t3_pop_full");
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (sym_ready_o) begin
                acc++;
                exp_q.push_back(mk(exp_idx, 12'h001));
                exp_idx++;
            end
            @(negedge clk_i);
        end
        sym_valid_i = 1'b0;
        chk("t3_one_more", 64'(acc), 64'(1));
        for (int k = 0; k < 8; k++) pop_chk("t3_drain");
        #1;
        chk("t3_empty_valid", 64'(rpt_valid_o), 64'(0));
        chk("t3_empty_data", 64'(rpt_data_o), 64'(0));
        rpt_ready_i = 1'b1;
        @(negedge clk_i);
        rpt_ready_i = 1'b0;
        #1;
        chk("t3_pop_empty", 64'(rpt_cnt_o), 64'(0));

        // self-loop STE and soft clear
        run_i = 1'b0;
        cfg(2'd2, 4'd0, 3'd0, 32'h0);
        cfg(2'd1, 4'd2, 3'd0, 32'h4);
        cfg(2'd0, 4'd2, 3'd0, 32'hFFFF_FFFF);
        cfg(2'd0, 4'd2, 3'd1, 32'hFFFF_FFFF);
        cfg(2'd2, 4'd2, 3'd0, 32'h1);
        do_clear();
        run_i = 1'b1;
        send(8'h10);
        chk("t4_a10", 64'(active_o), 64'h004);
        send(8'h20);
        chk("t4_a20", 64'(active_o), 64'h004);
        send(8'h50);
        chk("t4_a50", 64'(active_o), 64'h000);
        send(8'h10);
        chk("t4_sod_spent", 64'(active_o), 64'h000);
        do_clear();
        #1;
        chk("t4_clr_act", 64'(active_o), 64'h000);
        send(8'h10);
        chk("t4_rearm", 64'(active_o), 64'h004);

        // config protection
        cfg(2'd0, 4'd3, 3'd0, 32'hFFFF_FFFF);
        #1;
        chk("t5_err_run", 64'(cfg_err_o), 64'(1));
        @(negedge clk_i); #1;
        chk("t5_err_pulse", 64'(cfg_err_o), 64'(0));
        run_i = 1'b0;
        cfg(2'd2, 4'd3, 3'd0, 32'h2);
        #1;
        chk("t5_ok_flags", 64'(cfg_err_o), 64'(0));
        run_i = 1'b1;
        send(8'h01);
        chk("t5_unchanged", 64'(active_o[3]), 64'(0));
        run_i = 1'b0;
        cfg(2'd0, 4'd3, 3'd0, 32'hFFFF_FFFF);
        #1;
        chk("t5_ok_cls", 64'(cfg_err_o), 64'(0));
        cfg(2'd0, 4'd12, 3'd0, 32'hFFFF_FFFF);
        #1;
        chk("t5_err_ste", 64'(cfg_err_o), 64'(1));
        cfg(2'd3, 4'd0, 3'd0, 32'hFFFF_FFFF);
        #1;
        chk("t5_err_sel", 64'(cfg_err_o), 64'(1));
        run_i = 1'b1;
        send(8'h01);
        chk("t5_written", 64'(active_o[3]), 64'(1));

`ifdef AUTOMATA_REPORT_TS_EN
        // index wrap in the timestamp
        run_i = 1'b0;
        cfg(2'd2, 4'd0, 3'd0, 32'h6);
        do_clear();
        force dut.sym_idx_q = 32'hFFFF_FFFE;
        #1;
        release dut.sym_idx_q;
        exp_idx = 32'hFFFF_FFFE;
        run_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(exp_idx, 12'h001));
            send(8'h20);
        end
        @(negedge clk_i);
        for (int k = 0; k < 3; k++) pop_chk("t6_ts");
        run_i = 1'b0;
        cfg(2'd2, 4'd0, 3'd0, 32'h0);
`endif

        // async reset mid-stream
        run_i = 1'b0;
        cfg(2'd2, 4'd3, 3'd0, 32'h6);
        run_i = 1'b1;
        send(8'h01);
        @(posedge clk_i); #2;
        chk("t7_pre_cnt", 64'(rpt_cnt_o), 64'(1));
        rst_ni = 1'b0;
        #1;
        chk("t7_act", 64'(active_o), 64'(0));
        chk("t7_rep", 64'(report_o), 64'(0));
        chk("t7_cnt", 64'(rpt_cnt_o), 64'(0));
        chk("t7_data", 64'(rpt_data_o), 64'(0));
        chk("t7_ready", 64'(sym_ready_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        exp_q.delete();
        exp_idx = 0;
        run_i = 1'b0;
        cfg(2'd2, 4'd1, 3'd0, 32'h1);
        cfg(2'd2, 4'd2, 3'd0, 32'h1);
        cfg(2'd0, 4'd2, 3'd0, 32'hFFFF_FFFF);
        run_i = 1'b1;
        send(8'h10);
        chk("t7_sod_rearm", 64'(active_o), 64'h004);
        send(8'h10);
        chk("t7_cfg_zero", 64'(active_o), 64'h000);
        chk("t7_sb_left", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
